stall_sequencer: RTL and testbench
==================================

// Module: stall_sequencer
// PURPOSE
// - Consumes the Stall/StallWrite request from the ID-stage control hazard detector and applies it to the pipeline.
// - Freezes PC and IF/ID and injects an ID/EX bubble for the number of stall cycles requested.
// - Masks new requests while a multi-cycle stall is in progress.
// - Also generates the IF/ID flush for taken branches.
// - Sits between the ID hazard logic and the PC, IF/ID and ID/EX pipeline registers.
// PARAMETERS
// - LONG_STALL  2  total stall cycles when StallWrite=1 (legal range >=2); short stall is always 1 cycle
// PORTS
// - clk          in   1   pipeline clock
// - rst          in   1   synchronous reset, active-high
// - Stall        in   1   stall request from the hazard detector (only 1'b1 counts as a request)
// - StallWrite   in   1   long-stall qualifier; valid only when Stall=1
// - BranchTaken  in   1   ID-stage branch resolved taken
// - Halt         in   1   freeze the pipeline front end (HLT)
// - PCWrite      out  1   PC register write enable
// - IFIDWrite    out  1   IF/ID register write enable
// - IDEXBubble   out  1   load a NOP into ID/EX
// - IFIDFlush    out  1   clear IF/ID (squash the fetched instruction)
// - Stalling     out  1   a stall cycle is in effect this cycle
// - StallCount   out  16  stall-cycle statistic (present only with STALL_STATS_EN)
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset: while rst=1, outputs are PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, Stalling=0.
//   - The next state is IDLE and Remaining=0.
//   - Reset applies mid-stall: the stall is abandoned and the pipeline resumes normal flow.
// - State: FSM {IDLE, HOLD} plus a down-counter Remaining of width $clog2(LONG_STALL).
// - Output timing: outputs are combinational from state and inputs (0-cycle latency).
//   - A stall takes effect in the same cycle it is requested.
// - Halt=1 (highest priority after rst):
//   - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=0, IFIDFlush=0, Stalling=0.
//   - State and Remaining are frozen.
// - IDLE, Stall=1:
//   - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, Stalling=1.
//   - StallWrite=0: stay in IDLE (1-cycle stall).
//   - StallWrite=1: go to HOLD with Remaining=LONG_STALL-1.
// - IDLE, Stall!=1:
//   - Outputs: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=BranchTaken, Stalling=0.
// - HOLD:
//   - Outputs are the same as IDLE+Stall.
//   - Stall, StallWrite and BranchTaken are ignored.
//   - Remaining decrements each cycle; the FSM goes to IDLE on the cycle Remaining==1.
// - Simultaneous Stall and BranchTaken in IDLE: the stall wins and IFIDFlush=0.
//   - The branch re-resolves after the stall.
// - A Stall re-asserted in the first IDLE cycle after HOLD is a new request and is honoured.
// - StallWrite with Stall=0 has no effect.
// CONFIGURATION
// - STALL_STATS_EN defined:
//   - StallCount port exists; reset value is 0.
//   - It increments on every cycle with Stalling=1 (not Halt) and saturates at 16'hFFFF.
// - STALL_STATS_EN undefined:
//   - StallCount port and counter are absent; all other behaviour is identical.
// TESTING
// - Short stall: Stall=1, StallWrite=0 for 1 cycle.
//   - That cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
//   - Next cycle: PCWrite=1, IDEXBubble=0.
// - Long stall: Stall=1, StallWrite=1 for 1 cycle, then 0.
//   - Exactly 2 consecutive cycles with Stalling=1, then normal flow.
// - Masking: Stall=StallWrite=1 held during HOLD.
//   - The second cycle of the long stall ignores it.
//   - The request is honoured again in the first IDLE cycle.
// - Branch: BranchTaken=1 alone gives IFIDFlush=1 in the same cycle.
//   - BranchTaken=1 together with Stall=1 gives IFIDFlush=0 and IDEXBubble=1.
// - Reset mid-stall: rst=1 in the HOLD cycle.
//   - Next cycle: IDLE, PCWrite=1, Stalling=0.
// - Halt: long stall, then Halt=1 for 3 cycles in HOLD.
//   - Outputs are frozen with IDEXBubble=0.
//   - After Halt=0: 1 further stall cycle.
//   - With STALL_STATS_EN: StallCount=2.

Source files
------------

// File: rtl/stall_sequencer_if.sv
// stall_sequencer_if
//   Groups the hazard-detector request lines and the pipeline-control
//   outputs of the stall sequencer into a single bundle.
//
//   Request side (driven by the hazard logic / master):
//     Stall, StallWrite, BranchTaken, Halt
//   Control side (driven by the sequencer / slave):
//     PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalling
//     StallCount (16 bit, only when STALL_STATS_EN is defined)
//
//   Build option: STALL_STATS_EN adds the StallCount statistic line.
interface stall_sequencer_if;
  logic        Stall;
  logic        StallWrite;
  logic        BranchTaken;
  logic        Halt;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
  logic        Stalling;
`ifdef STALL_STATS_EN
  logic [15:0] StallCount;

  modport master (
    output Stall, StallWrite, BranchTaken, Halt,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalling, StallCount
  );

  modport slave (
    input  Stall, StallWrite, BranchTaken, Halt,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalling, StallCount
  );
`else
  modport master (
    output Stall, StallWrite, BranchTaken, Halt,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalling
  );

  modport slave (
    input  Stall, StallWrite, BranchTaken, Halt,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalling
  );
`endif
endinterface

// File: rtl/stall_sequencer.sv
// stall_sequencer
//   Applies the ID-stage hazard detector's stall request to the pipeline
//   front end: freezes PC and IF/ID, injects an ID/EX bubble for one cycle
//   (short stall) or LONG_STALL cycles (long stall), masks new requests
//   while a long stall is running, and flushes IF/ID on a taken branch.
//
//   Ports:
//     clk  - pipeline clock
//     rst  - synchronous reset, active-high
//     bus  - stall_sequencer_if.slave (requests in, pipeline controls out)
//
//   Parameter:
//     LONG_STALL - total stall cycles for a long stall (>= 2)
//
//   Build option: STALL_STATS_EN enables the saturating 16-bit StallCount
//   statistic; without it the counter does not exist.
module stall_sequencer #(
  parameter int LONG_STALL = 2
) (
  input  logic              clk,
  input  logic              rst,
  stall_sequencer_if.slave  bus
);

  localparam int RW = $clog2(LONG_STALL);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_remaining;

  logic w_stallReq;
  logic w_stallCycle;

  // Only a clean 1 on Stall is a request; HOLD ignores requests entirely.
  assign w_stallReq   = (bus.Stall == 1'b1);
  assign w_stallCycle = !rst && !bus.Halt && ((r_state == HOLD) || w_stallReq);

  // Outputs follow state and inputs in the same cycle so a stall bites
  // immediately. Halt freezes the front end without issuing a bubble.
  always_comb begin
    bus.PCWrite    = 1'b1;
    bus.IFIDWrite  = 1'b1;
    bus.IDEXBubble = 1'b0;
    bus.IFIDFlush  = 1'b0;
    bus.Stalling   = 1'b0;
    if (rst) begin
      bus.PCWrite   = 1'b1;
    end else if (bus.Halt) begin
      bus.PCWrite   = 1'b0;
      bus.IFIDWrite = 1'b0;
    end else if (w_stallCycle) begin
      bus.PCWrite    = 1'b0;
      bus.IFIDWrite  = 1'b0;
      bus.IDEXBubble = 1'b1;
      bus.Stalling   = 1'b1;
    end else begin
      bus.IFIDFlush  = bus.BranchTaken;
    end
  end

  // The first stall cycle happens in IDLE, so HOLD covers the remaining
  // LONG_STALL-1 cycles and returns to IDLE on the cycle Remaining reaches 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else if (!bus.Halt) begin
      case (r_state)
        IDLE: begin
          if (w_stallReq && bus.StallWrite) begin
            r_state     <= HOLD;
            r_remaining <= RW'(LONG_STALL - 1);
          end
        end
        HOLD: begin
          r_remaining <= r_remaining - RW'(1);
          if (r_remaining == RW'(1)) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_remaining <= '0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [15:0] r_stallCount;

  // Counts cycles that actually bubbled; halted cycles are excluded
  // because they never assert Stalling. Saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (w_stallCycle && (r_stallCount != 16'hFFFF)) begin
      r_stallCount <= r_stallCount + 16'd1;
    end
  end

  assign bus.StallCount = r_stallCount;
`endif

endmodule

// File: tb/tb_stall_sequencer.sv
// tb_stall_sequencer
//   Self-checking bench for stall_sequencer. Every cycle the outputs are
//   compared against a reference model that tracks only "how many stall
//   cycles are still owed" and a running stall-cycle tally.
//   Honours STALL_STATS_EN the same way as the design.
module tb_stall_sequencer;

  localparam int LONG_STALL = 2;

  logic clk;
  logic rst;

  int checkCount;
  int errorCount;

  int stallLeft;
  int statCount;

  stall_sequencer_if busIf();

  stall_sequencer #(
    .LONG_STALL(LONG_STALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks the combinational
  // outputs against the model shortly after, then advances the model to
  // what the next rising edge should produce.
  task automatic applyStimulus(input logic iRst, input logic iStall, input logic iSw,
                               input logic iBr, input logic iHalt);
    logic ePc, eIf, eBub, eFl, eSt;
    @(negedge clk);
    rst               = iRst;
    busIf.Stall       = iStall;
    busIf.StallWrite  = iSw;
    busIf.BranchTaken = iBr;
    busIf.Halt        = iHalt;
    #1;
    ePc = 1'b1; eIf = 1'b1; eBub = 1'b0; eFl = 1'b0; eSt = 1'b0;
    if (iRst) begin
      ePc = 1'b1;
    end else if (iHalt) begin
      ePc = 1'b0; eIf = 1'b0;
    end else if (stallLeft > 0 || iStall) begin
      ePc = 1'b0; eIf = 1'b0; eBub = 1'b1; eSt = 1'b1;
    end else begin
      eFl = iBr;
    end
    checkOutput("PCWrite",    {15'd0, busIf.PCWrite},    {15'd0, ePc});
    checkOutput("IFIDWrite",  {15'd0, busIf.IFIDWrite},  {15'd0, eIf});
    checkOutput("IDEXBubble", {15'd0, busIf.IDEXBubble}, {15'd0, eBub});
    checkOutput("IFIDFlush",  {15'd0, busIf.IFIDFlush},  {15'd0, eFl});
    checkOutput("Stalling",   {15'd0, busIf.Stalling},   {15'd0, eSt});
`ifdef STALL_STATS_EN
    checkOutput("StallCount", busIf.StallCount, 16'(statCount));
`endif
    if (iRst) begin
      stallLeft = 0;
      statCount = 0;
    end else if (!iHalt) begin
      if (eSt && statCount < 65535) statCount++;
      if (stallLeft > 0) stallLeft--;
      else if (iStall && iSw) stallLeft = LONG_STALL - 1;
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    stallLeft  = 0;
    statCount  = 0;

    rst               = 1'b1;
    busIf.Stall       = 1'b0;
    busIf.StallWrite  = 1'b0;
    busIf.BranchTaken = 1'b0;
    busIf.Halt        = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] directed sequences");
    // reset state, then normal flow
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    // short stall, then recovery
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    // long stall requested for one cycle
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    // StallWrite alone does nothing
    applyStimulus(0, 0, 1, 0, 0);
    // request held through HOLD, honoured again right after
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    // branch alone, then branch losing to a stall, branch ignored in HOLD
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    // reset during HOLD abandons the stall
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    // halt inside a long stall freezes it for three cycles
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
`ifdef STALL_STATS_EN
    #1;
    checkOutput("haltStallCount", busIf.StallCount, 16'd2);
`endif

    $display("[TB] randomized sequences");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 2) == 0),
                    1'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
